store_buffer_ctrl: RTL
======================

// Module: store_buffer_ctrl
// PURPOSE
//   Store queue and data-memory write sequencer between the MEM stage and the dmem port.
//   Accepts stores (addr, funct3, raw rs2 data) and aligns each at enqueue into a
//   word address, byte mask and lane-replicated data.
//   Drains entries in order to dmem with a write/resp handshake.
//   Flags loads that hit a pending store word so the hazard unit can stall.
// PARAMETERS
//   DEPTH   4   queue entries; power of two, >= 2
//   CNT_W   $clog2(DEPTH)+1   width of occupancy count
// PORTS
//   clk           in   1      clock, all state on rising edge
//   rst_n         in   1      asynchronous, active-low reset
//   st_valid      in   1      store request valid
//   st_ready      out  1      queue can accept a store this cycle
//   st_addr       in   32     byte address of store
//   st_funct3     in   3      store_funct3_t: sb=000, sh=001, sw=010
//   st_wdata      in   32     unaligned store data (rs2)
//   st_err        out  1      accepted handshake carried illegal funct3 (dropped)
//   st_misalign   out  1      misaligned store rejected (MISALIGN_TRAP_EN only)
//   ld_valid      in   1      load in MEM stage
//   ld_addr       in   32     load byte address
//   ld_hazard     out  1      load word matches a pending store
//   dmem_write    out  1      write request to data memory
//   dmem_address  out  32     word-aligned address {addr[31:2],2'b00}
//   dmem_wmask    out  4      byte enables
//   dmem_wdata    out  32     lane-aligned write data
//   dmem_resp     in   1      write complete; pops head
//   sb_count      out  CNT_W  entries held (incl. in-flight head)
//   sb_empty      out  1      sb_count == 0
// BEHAVIOUR
//   - Reset: pointers/count = 0, state IDLE; all outputs 0 except st_ready=1, sb_empty=1.
//   - Push = st_valid & st_ready & legal (& aligned if trap enabled). st_ready = (sb_count != DEPTH).
//   - Alignment at enqueue, off = st_addr[1:0]:
//     sb: data = {4{wdata[7:0]}}, mask = 4'b0001 << off.
//     sh: data = {2{wdata[15:0]}}, mask = off[1] ? 4'b1100 : 4'b0011.
//     sw: data = wdata, mask = 4'b1111.
//   - Illegal funct3 with st_valid & st_ready: no entry; st_err=1 that cycle (comb).
//   - FSM IDLE/WRITE. IDLE->WRITE when count!=0 or push.
//     WRITE->IDLE on dmem_resp when count==1 and no push; otherwise stay WRITE.
//   - dmem_write = (state==WRITE); address/mask/data driven from head entry, stable until dmem_resp.
//   - Latency: push in cycle N -> dmem_write high in N+1 with that entry (queue empty before).
//   - dmem_resp pops head at the edge; next entry is presented the following cycle, back-to-back,
//     with no idle cycle. dmem_resp outside WRITE is ignored.
//   - Simultaneous push+pop: count unchanged. Pointers wrap modulo DEPTH.
//   - Full: st_ready=0, and stays 0 in the same cycle even if dmem_resp pops (no bypass).
//   - ld_hazard (comb) = ld_valid & any occupied entry with addr[31:2]==ld_addr[31:2].
//     Includes the in-flight head; excludes a store being pushed in the same cycle.
//   - Reset mid-write: queue discarded and dmem_write drops immediately (async); write abandoned.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined:
//     - sh with off[0]=1 or sw with off!=0: not enqueued; st_misalign=1 that cycle (comb).
//     - st_ready is unaffected.
//   MISALIGN_TRAP_EN undefined:
//     - st_misalign tied 0.
//     - Misaligned sh/sw are enqueued using only the alignment rules above (low bits ignored).
// TESTING
//   1. sb addr 0x1003 data 0xAB, resp after 2 cycles -> next cycle dmem_write=1,
//      addr 0x1000, mask 1000, wdata 0xABABABAB; IDLE after resp.
//   2. sh addr 0x2002 data 0x1234CAFE -> mask 1100, wdata 0xCAFECAFE.
//      sw 0x3000 -> mask 1111, wdata unchanged.
//   3. DEPTH pushes with dmem_resp low -> sb_count=DEPTH, st_ready=0.
//      Resp each cycle -> four back-to-back writes in order; pointers wrap; sb_empty=1.
//   4. Push and resp in same cycle with count=2 -> count stays 2; order preserved.
//   5. Pending sw 0x4000, load 0x4003 -> ld_hazard=1; load 0x4004 -> 0; after resp, 0x4003 -> 0.
//   6. funct3=3'b111 -> st_err=1, no entry. With MISALIGN_TRAP_EN: sw 0x5001 -> st_misalign=1, no write.
//      Reset asserted mid-WRITE -> dmem_write=0 immediately, sb_count=0.

Source files
------------

// File: rtl/store_buffer_ctrl.sv
// store_buffer_ctrl: in-order store queue between the MEM stage and the data-memory write port.
//   Stores are aligned at enqueue into a word address, a byte mask and lane-replicated data.
//   Entries then drain one at a time over a dmem_write/dmem_resp handshake.
//   A load whose word address matches any held entry raises ld_hazard.
// Build option: define MISALIGN_TRAP_EN to reject misaligned sh/sw and report them on st_misalign.
//   Without it, st_misalign is tied 0 and the low address bits of sh/sw are ignored.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   st_valid/st_ready                store request handshake
//   st_addr, st_funct3, st_wdata     store byte address, size (sb/sh/sw), raw rs2 data
//   st_err, st_misalign              combinational reject flags for the current handshake
//   ld_valid, ld_addr, ld_hazard     load word-match check against held stores
//   dmem_write/address/wmask/wdata   write request driven from the queue head
//   dmem_resp                        write complete, pops the head
//   sb_count, sb_empty               occupancy, including the in-flight head
module store_buffer_ctrl #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [2:0]       st_funct3,
  input  logic [31:0]      st_wdata,
  output logic             st_err,
  output logic             st_misalign,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic             ld_hazard,
  output logic             dmem_write,
  output logic [31:0]      dmem_address,
  output logic [3:0]       dmem_wmask,
  output logic [31:0]      dmem_wdata,
  input  logic             dmem_resp,
  output logic [CNT_W-1:0] sb_count,
  output logic             sb_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  mask;
    logic [31:0] data;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [0:0]         state_q, state_d;

  logic               legal;
  logic               misaligned;
  logic               handshake;
  logic               push;
  logic               pop;
  logic [1:0]         off;
  entry_t             new_entry;
  entry_t             head;
  logic               hit;
  logic               ld_unused;

  assign off       = st_addr[1:0];
  assign legal     = (st_funct3 == F3_SB) || (st_funct3 == F3_SH) || (st_funct3 == F3_SW);
  assign handshake = st_valid & st_ready;

`ifdef MISALIGN_TRAP_EN
  assign misaligned  = ((st_funct3 == F3_SH) && off[0]) || ((st_funct3 == F3_SW) && (off != 2'b00));
  assign st_misalign = handshake & legal & misaligned;
`else
  assign misaligned  = 1'b0;
  assign st_misalign = 1'b0;
`endif

  assign st_err = handshake & ~legal;
  assign push   = handshake & legal & ~misaligned;
  assign pop    = (state_q == S_WRITE) & dmem_resp;

  // Lane alignment of the incoming store
  always_comb begin
    new_entry       = '0;
    new_entry.waddr = st_addr[31:2];
    unique case (st_funct3)
      F3_SB: begin
        new_entry.mask = 4'b0001 << off;
        new_entry.data = {4{st_wdata[7:0]}};
      end
      F3_SH: begin
        new_entry.mask = off[1] ? 4'b1100 : 4'b0011;
        new_entry.data = {2{st_wdata[15:0]}};
      end
      default: begin
        new_entry.mask = 4'b1111;
        new_entry.data = st_wdata;
      end
    endcase
  end

  // Next-state: pointers, occupancy and FSM
  always_comb begin
    state_d  = state_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    valid_d  = valid_q;
    if (pop)  valid_d[rd_ptr_q] = 1'b0;
    if (push) valid_d[wr_ptr_q] = 1'b1;
    unique case (state_q)
      S_IDLE:  if ((count_q != '0) || push) state_d = S_WRITE;
      S_WRITE: if (pop && (count_q == CNT_W'(1)) && !push) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by valid_q
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  // Word match against every held entry, in-flight head included
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (mem_q[i].waddr == ld_addr[31:2])) hit = 1'b1;
    end
  end

  assign ld_unused = ^ld_addr[1:0];
  assign ld_hazard = ld_valid & hit;

  assign head         = mem_q[rd_ptr_q];
  assign dmem_write   = (state_q == S_WRITE);
  assign dmem_address = dmem_write ? {head.waddr, 2'b00} : 32'h0;
  assign dmem_wmask   = dmem_write ? head.mask : 4'h0;
  assign dmem_wdata   = dmem_write ? head.data : 32'h0;

  assign st_ready = (count_q != CNT_W'(DEPTH));
  assign sb_count = count_q;
  assign sb_empty = (count_q == '0);

endmodule
